// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a req/ack
// port and hands it to decode. Branch/jump redirects are resolved at acceptance.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  OP,
  output logic [5:0]  Funct,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  output logic        fetch_err
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   instr_q;
  logic [CW-1:0] cnt;
  logic          req_q;
  logic          valid_q;
  logic          err_q;

  logic [31:0]   branch_off;
  logic [31:0]   jump_target;
  logic [31:0]   next_pc;

  assign pc_plus4    = pc + 32'd4;
  assign branch_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jump_target = {pc_plus4[31:28], instr_q[25:0], 2'b00};

  // Jump outranks a taken branch when the control unit asserts both.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump)
      next_pc = jump_target;
    else if (Branch && Zero)
      next_pc = pc_plus4 + branch_off;
  end

  // Decode handshake: a word transfers on any cycle where instr_valid and
  // instr_ready are both high; instr_valid never drops without that transfer
  // (except under reset) and instr/pc stay frozen while it is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= 32'd0;
      cnt     <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          // An ack in the last allowed cycle still counts as a good fetch.
          if (imem_ack) begin
            instr_q <= imem_rdata;
            cnt     <= '0;
            state   <= HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state <= ERR;
            req_q <= 1'b0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc      <= next_pc;
            state   <= FETCH;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state <= ERR;
        end
      endcase
    end
  end

  assign imem_addr   = pc;
  assign imem_req    = req_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;
  assign instr       = instr_q;
  assign OP          = instr_q[31:26];
  assign Funct       = instr_q[5:0];
  assign pc_out      = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetch/accept sequences; a negedge monitor
// checks each new fetch address and each presented instruction against queues.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  OP;
  logic [5:0]  Funct;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        Branch;
  logic        Zero;
  logic        Jump;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [95:0] exp_hold_q[$];  // {instr, pc, pc_plus4}

  logic prev_req   = 1'b0;
  logic prev_valid = 1'b0;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .OP         (OP),
    .Funct      (Funct),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .Branch     (Branch),
    .Zero       (Zero),
    .Jump       (Jump),
    .fetch_err  (fetch_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (imem_req === 1'b1 && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_fetch addr=%h", imem_addr);
      end else begin
        chk("fetch_addr", imem_addr, exp_addr_q[0]);
        void'(exp_addr_q.pop_front());
      end
    end
    if (instr_valid === 1'b1 && !prev_valid) begin
      if (exp_hold_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid instr=%h", instr);
      end else begin
        chk("hold_instr", instr, exp_hold_q[0][95:64]);
        chk("hold_op", {26'd0, OP}, {26'd0, exp_hold_q[0][95:90]});
        chk("hold_funct", {26'd0, Funct}, {26'd0, exp_hold_q[0][69:64]});
        chk("hold_pc", pc_out, exp_hold_q[0][63:32]);
        chk("hold_pc_plus4", pc_plus4, exp_hold_q[0][31:0]);
        void'(exp_hold_q.pop_front());
      end
    end
    prev_req   <= (imem_req === 1'b1);
    prev_valid <= (instr_valid === 1'b1);
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] data, input int waits);
    chk("req_before_ack", {31'd0, imem_req}, 32'd1);
    tick(waits);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick(1);
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic accept(input logic [31:0] exp_instr, input int stall,
                        input logic b, input logic z, input logic j);
    instr_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      Branch = 1'b1; Zero = 1'b1; Jump = 1'b1;
      tick(1);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, exp_instr);
    end
    instr_ready = 1'b1;
    Branch = b; Zero = z; Jump = j;
    tick(1);
    instr_ready = 1'b0;
    Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
    chk("post_accept_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_accept_req", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic step(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] pc4,
                      input int waits, input logic [31:0] nxt,
                      input logic b, input logic z, input logic j);
    exp_hold_q.push_back({w, pc, pc4});
    fetch(w, waits);
    exp_addr_q.push_back(nxt);
    accept(w, 0, b, z, j);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
    Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;

    // reset / boot
    tick(1);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_op", {26'd0, OP}, 32'd0);
    chk("rst_funct", {26'd0, Funct}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    tick(2);
    exp_addr_q.push_back(32'h0000_0000);
    rst_n = 1'b1;
    tick(1);
    chk("boot_req", {31'd0, imem_req}, 32'd1);

    exp_hold_q.push_back({32'h2008_0005, 32'h0, 32'h4});
    fetch(32'h2008_0005, 0);
    chk("boot_op", {26'd0, OP}, 32'd8);
    chk("boot_funct", {26'd0, Funct}, 32'd5);
    chk("boot_pc_plus4", pc_plus4, 32'd4);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(1);
    imem_ack = 1'b0; imem_rdata = 32'd0;
    chk("stray_ack_hold", instr, 32'h2008_0005);
    exp_addr_q.push_back(32'h0000_0004);
    accept(32'h2008_0005, 5, 1'b0, 1'b0, 1'b0);

    // sequential, branch taken / not taken, wrap, jump priority
    step(32'h0000_0020, 32'h4, 32'h8, 2, 32'h8, 1'b0, 1'b0, 1'b0);
    step(32'h1000_FFFE, 32'h8, 32'hC, 1, 32'h4, 1'b1, 1'b1, 1'b0);
    step(32'h0000_0020, 32'h4, 32'h8, 0, 32'h8, 1'b0, 1'b0, 1'b0);
    step(32'h1000_FFFE, 32'h8, 32'hC, 0, 32'hC, 1'b1, 1'b0, 1'b0);
    step(32'h1000_FFFE, 32'hC, 32'h10, 3, 32'h10, 1'b0, 1'b1, 1'b0);
    step(32'h1000_FFF9, 32'h10, 32'h14, 0, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);
    step(32'h0000_0020, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    step(32'h0000_0020, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(32'h1000_FFFD, 32'h0, 32'h4, 0, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);
    step(32'h0800_0040, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 32'hF000_0100, 1'b1, 1'b1, 1'b1);

    // watchdog: no ack for 15 FETCH cycles
    tick(14);
    chk("wd_req_cycle15", {31'd0, imem_req}, 32'd1);
    chk("wd_err_cycle15", {31'd0, fetch_err}, 32'd0);
    tick(1);
    chk("wd_err", {31'd0, fetch_err}, 32'd1);
    chk("wd_req", {31'd0, imem_req}, 32'd0);
    chk("wd_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    tick(1);
    imem_ack = 1'b0;
    chk("wd_err_sticky", {31'd0, fetch_err}, 32'd1);
    exp_addr_q.push_back(32'h0000_0000);
    rst_n = 1'b0;
    tick(1);
    chk("wd_rst_err", {31'd0, fetch_err}, 32'd0);
    chk("wd_rst_pc", pc_out, 32'd0);
    chk("wd_rst_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    exp_hold_q.push_back({32'h2008_0005, 32'h0, 32'h4});
    fetch(32'h2008_0005, 14);
    chk("ack_last_cycle_err", {31'd0, fetch_err}, 32'd0);

    // reset while holding, stray ack in reset and IDLE
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick(1);
    chk("midhold_valid", {31'd0, instr_valid}, 32'd0);
    chk("midhold_pc", pc_out, 32'd0);
    chk("midhold_instr", instr, 32'd0);
    rst_n = 1'b1;
    exp_addr_q.push_back(32'h0000_0000);
    tick(1);
    imem_ack = 1'b0; imem_rdata = 32'd0;
    chk("idle_ack_instr", instr, 32'd0);
    chk("idle_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    step(32'h0000_0020, 32'h0, 32'h4, 1, 32'h4, 1'b0, 1'b0, 1'b0);

    // final report
    tick(2);
    chk("addr_q_empty", exp_addr_q.size(), 32'd0);
    chk("hold_q_empty", exp_hold_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
